// File: rtl/window_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : window_pkg
//  Description : Shared definitions for the NxN sliding-window generator:
//                FSM state encoding, legal window-size limits and the
//                (row, col) -> bit-offset helper for the packed window bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package window_pkg;

    // Legal window edge lengths (odd values only, checked in the top level)
    localparam int WIN_MIN = 3;
    localparam int WIN_MAX = 7;

    // Frame-tracking FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a start-of-frame pixel
        ST_FILL = 2'd1,   // first WIN-1 lines, line buffers still filling
        ST_RUN  = 2'd2    // enough lines buffered to form full windows
    } state_e;

    // Bit offset of tap (r, c) inside the packed window; r=0 is the oldest
    // line and c=0 the oldest column.
    function automatic int tap_offset(input int r, input int c,
                                      input int win, input int data_w);
        return ((r * win) + c) * data_w;
    endfunction

endpackage : window_pkg
`default_nettype wire

// File: rtl/line_buf_ram.sv
`default_nettype none
// ============================================================================
//  Module      : line_buf_ram
//  Description : Simple dual-port RAM holding all WIN-1 line buffers packed
//                into one word per column. One write port, one read port
//                with a single registered read cycle. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buf_ram #(
    parameter int DEPTH  = 640,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write port and registered read port; a same-address read returns the
    // previous contents.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : line_buf_ram
`default_nettype wire

// File: rtl/window_nxn_gen.sv
`default_nettype none
// ============================================================================
//  Module      : window_nxn_gen
//  Description : Raster-scan NxN sliding-window generator. Pixels enter one
//                per qualified cycle; WIN-1 line buffers supply the pixels
//                directly above, and a WIN x WIN shift register forms the
//                window. Output follows the accepted pixel by two cycles.
//                Build option WINDOW_ZERO_PAD_EN: emit a window for every
//                pixel, with taps outside the frame forced to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module window_nxn_gen
    import window_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int WIN    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic                       i_sof,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_valid,
    output logic [WIN*WIN*DATA_W-1:0]  o_window,
    output logic                       o_sof,
    output logic                       o_eof
);

    localparam int C_COL_W  = $clog2(IMG_W);
    localparam int C_ROW_W  = $clog2(IMG_H);
    localparam int C_LB_W   = (WIN - 1) * DATA_W;
    localparam int C_WIN_W  = WIN * WIN * DATA_W;

    localparam logic [C_COL_W-1:0] C_LAST_COL = C_COL_W'(IMG_W - 1);
    localparam logic [C_ROW_W-1:0] C_LAST_ROW = C_ROW_W'(IMG_H - 1);
    localparam logic [C_ROW_W-1:0] C_FILL_ROW = C_ROW_W'(WIN - 2);
    localparam logic [C_ROW_W-1:0] C_RUN_ROW  = C_ROW_W'(WIN - 1);
    localparam logic [C_COL_W-1:0] C_RUN_COL  = C_COL_W'(WIN - 1);

    // Reject unsupported configurations at elaboration time
    generate
        if ((WIN < WIN_MIN) || (WIN > WIN_MAX) || ((WIN % 2) == 0)) begin : g_bad_win
            $error("window_nxn_gen: WIN must be odd and within 3..7");
        end
        if ((IMG_W < 8) || (IMG_W > 4096) || (IMG_H < 8) || (IMG_H > 4096)) begin : g_bad_img
            $error("window_nxn_gen: IMG_W and IMG_H must be within 8..4096");
        end
    endgenerate

    state_e               r_state;
    state_e               w_state_next;
    logic                 w_accept;

    logic [C_COL_W-1:0]   r_col;
    logic [C_ROW_W-1:0]   r_row;
    logic [C_COL_W-1:0]   w_pix_col;
    logic [C_ROW_W-1:0]   w_pix_row;
    logic                 w_last_col;
    logic                 w_last_row;

    logic                 r_s1_valid;
    logic [DATA_W-1:0]    r_s1_pix;
    logic [C_COL_W-1:0]   r_s1_col;
    logic [C_ROW_W-1:0]   r_s1_row;

    logic [C_LB_W-1:0]    w_lb_rd;
    logic [C_LB_W-1:0]    w_lb_wr;

    logic [DATA_W-1:0]    w_column [WIN];
    logic [C_WIN_W-1:0]   w_win_next;
    logic [C_WIN_W-1:0]   r_window;
    logic                 w_out_valid;
    logic                 w_out_sof;
    logic                 w_out_eof;
    logic                 r_valid;
    logic                 r_sof;
    logic                 r_eof;

    // A start-of-frame pixel always lands at (0,0), whatever the counters say
    assign w_pix_col  = i_sof ? '0 : r_col;
    assign w_pix_row  = i_sof ? '0 : r_row;
    assign w_last_col = (w_pix_col == C_LAST_COL);
    assign w_last_row = (w_pix_row == C_LAST_ROW);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: sof restarts from any state, row WIN-1 enters RUN,
    // the last pixel of the frame returns to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_valid && i_sof) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (i_valid) begin
                    if (i_sof) begin
                        w_state_next = ST_FILL;
                    end else if (w_last_col && (w_pix_row == C_FILL_ROW)) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_valid) begin
                    if (i_sof) begin
                        w_state_next = ST_FILL;
                    end else if (w_last_col && w_last_row) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: pixels are dropped in IDLE unless they start a frame
    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: w_accept = i_valid && i_sof;
            default: w_accept = i_valid;
        endcase
    end

    // Raster position counters, advanced once per accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : (w_pix_row + 1'b1);
            end else begin
                r_col <= w_pix_col + 1'b1;
                r_row <= w_pix_row;
            end
        end
    end

    // Stage 1: hold the pixel and its position alongside the line-buffer read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_pix <= i_data;
                r_s1_col <= w_pix_col;
                r_s1_row <= w_pix_row;
            end
        end
    end

    // Each line ages by one slot on write-back: slot 0 takes the new pixel,
    // the oldest line drops off the top.
    assign w_lb_wr = {w_lb_rd[C_LB_W-DATA_W-1:0], r_s1_pix};

    line_buf_ram #(
        .DEPTH  (IMG_W),
        .WIDTH  (C_LB_W),
        .ADDR_W (C_COL_W)
    ) u_line_buf_ram (
        .clk       (clk),
        .i_wr_en   (r_s1_valid),
        .i_wr_addr (r_s1_col),
        .i_wr_data (w_lb_wr),
        .i_rd_en   (w_accept),
        .i_rd_addr (w_pix_col),
        .o_rd_data (w_lb_rd)
    );

    // New window column: line slot k holds row-1-k, so window row r maps to
    // slot WIN-2-r; the bottom row is the incoming pixel itself
    always_comb begin
        for (int r = 0; r < WIN - 1; r++) begin
            w_column[r] = w_lb_rd[(WIN-2-r)*DATA_W +: DATA_W];
`ifdef WINDOW_ZERO_PAD_EN
            if (int'(r_s1_row) < (WIN - 1 - r)) begin
                w_column[r] = '0;
            end
`endif
        end
        w_column[WIN-1] = r_s1_pix;
    end

    // Shift the window one column left and insert the new column at c=WIN-1
    always_comb begin
        w_win_next = r_window;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
                w_win_next[tap_offset(r, c, WIN, DATA_W) +: DATA_W] =
                    r_window[tap_offset(r, c + 1, WIN, DATA_W) +: DATA_W];
`ifdef WINDOW_ZERO_PAD_EN
                // Columns left of the frame edge would hold previous-line
                // wrap pixels; force them to zero
                if (int'(r_s1_col) < (WIN - 1 - c)) begin
                    w_win_next[tap_offset(r, c, WIN, DATA_W) +: DATA_W] = '0;
                end
`endif
            end
            w_win_next[tap_offset(r, WIN - 1, WIN, DATA_W) +: DATA_W] = w_column[r];
        end
    end

    // Output qualifiers for the window formed in stage 2
    always_comb begin
`ifdef WINDOW_ZERO_PAD_EN
        w_out_valid = r_s1_valid;
        w_out_sof   = r_s1_valid && (r_s1_row == '0) && (r_s1_col == '0);
`else
        w_out_valid = r_s1_valid && (r_s1_row >= C_RUN_ROW) && (r_s1_col >= C_RUN_COL);
        w_out_sof   = r_s1_valid && (r_s1_row == C_RUN_ROW) && (r_s1_col == C_RUN_COL);
`endif
        w_out_eof   = r_s1_valid && (r_s1_row == C_LAST_ROW) && (r_s1_col == C_LAST_COL);
    end

    // Stage 2: window register and output flags; the window holds on stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window <= '0;
            r_valid  <= 1'b0;
            r_sof    <= 1'b0;
            r_eof    <= 1'b0;
        end else begin
            r_valid <= w_out_valid;
            r_sof   <= w_out_sof;
            r_eof   <= w_out_eof;
            if (r_s1_valid) begin
                r_window <= w_win_next;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_window = r_window;
    assign o_sof    = r_sof;
    assign o_eof    = r_eof;

endmodule : window_nxn_gen
`default_nettype wire

// File: tb/tb_window_nxn_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_nxn_gen
//  Description : Directed self-checking bench for window_nxn_gen on an 8x6
//                frame with a 3x3 window, pixel value row*16+col. Expected
//                windows come from a frame-image model and are queued as
//                each pixel is driven, then popped two cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window_nxn_gen;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 6;
    localparam int WIN    = 3;
    localparam int NTAP   = WIN * WIN;
    localparam int WBITS  = NTAP * DATA_W;
`ifdef WINDOW_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int FRAME_WINS = PAD ? (IMG_W * IMG_H) : ((IMG_W - WIN + 1) * (IMG_H - WIN + 1));
    // Windows emitted by a frame aborted at pixel (3,4)
    localparam int ABORT_WINS = PAD ? (3 * IMG_W + 4) : ((IMG_W - WIN + 1) + 2);

    typedef struct {
        logic             valid;
        logic             sof;
        logic             eof;
        logic [WBITS-1:0] win;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_valid = 1'b0;
    logic              i_sof = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              o_valid;
    logic [WBITS-1:0]  o_window;
    logic              o_sof;
    logic              o_eof;

    exp_t        q[$];
    int          m_row, m_col;
    bit          m_active;
    logic [7:0]  img [IMG_H][IMG_W];
    int          n_assert, n_fail, obs_wins, obs_eof;
    logic [7:0]  first_tap22, last_tap22;

    window_nxn_gen #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .WIN    (WIN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_sof    (i_sof),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .o_window (o_window),
        .o_sof    (o_sof),
        .o_eof    (o_eof)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [WBITS-1:0] obs, input logic [WBITS-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("o_valid", {{(WBITS-1){1'b0}}, o_valid}, {{(WBITS-1){1'b0}}, e.valid});
        if (o_valid === 1'b1) obs_wins++;
        if (o_eof === 1'b1) obs_eof++;
        if (e.valid) begin
            chk("o_window", o_window, e.win);
            chk("o_sof", {{(WBITS-1){1'b0}}, o_sof}, {{(WBITS-1){1'b0}}, e.sof});
            chk("o_eof", {{(WBITS-1){1'b0}}, o_eof}, {{(WBITS-1){1'b0}}, e.eof});
            if (e.sof) first_tap22 = o_window[(NTAP-1)*DATA_W +: DATA_W];
            if (e.eof) last_tap22  = o_window[(NTAP-1)*DATA_W +: DATA_W];
        end
    endtask

    // Drive one cycle of input, build its expected window, check the output
    // due from the previous cycle's input
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        exp_t e;
        int sr, sc;
        e.valid = 1'b0; e.sof = 1'b0; e.eof = 1'b0; e.win = '0;
        if (v && (s || m_active)) begin
            if (s) begin
                m_row = 0; m_col = 0; m_active = 1'b1;
            end
            img[m_row][m_col] = d;
            e.valid = PAD || ((m_row >= WIN - 1) && (m_col >= WIN - 1));
            if (e.valid) begin
                for (int r = 0; r < WIN; r++) begin
                    for (int c = 0; c < WIN; c++) begin
                        sr = m_row - (WIN - 1) + r;
                        sc = m_col - (WIN - 1) + c;
                        if ((sr >= 0) && (sc >= 0)) e.win[(r*WIN+c)*DATA_W +: DATA_W] = img[sr][sc];
                    end
                end
                e.sof = PAD ? ((m_row == 0) && (m_col == 0)) : ((m_row == WIN - 1) && (m_col == WIN - 1));
                e.eof = (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
            end
            if (m_col == IMG_W - 1) begin
                m_col = 0;
                if (m_row == IMG_H - 1) begin
                    m_row = 0; m_active = 1'b0;
                end else begin
                    m_row++;
                end
            end else begin
                m_col++;
            end
        end
        i_valid = v; i_sof = s; i_data = d;
        @(posedge clk); #1;
        if (q.size() > 0) check_out(q.pop_front());
        q.push_back(e);
    endtask

    task automatic pix_val(input int r, input int c, input bit inv, output logic [7:0] v);
        v = 8'(r * 16 + c);
        if (inv) v = 8'hFF - v;
    endtask

    task automatic send_frame(input bit gaps, input bit inv);
        logic [7:0] v;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                pix_val(r, c, inv, v);
                step(1'b1, (r == 0) && (c == 0), v);
                if (gaps) step(1'b0, 1'b0, 8'h00);
            end
        end
    endtask

    task automatic flush();
        repeat (3) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"},  {{(WBITS-1){1'b0}}, o_valid}, '0);
        chk({tag, "_window"}, o_window, '0);
        chk({tag, "_sof"},    {{(WBITS-1){1'b0}}, o_sof}, '0);
        chk({tag, "_eof"},    {{(WBITS-1){1'b0}}, o_eof}, '0);
    endtask

    initial begin
        logic [7:0] v;
        n_assert = 0; n_fail = 0; obs_wins = 0; obs_eof = 0;
        m_row = 0; m_col = 0; m_active = 1'b0;
        first_tap22 = 8'hxx; last_tap22 = 8'hxx;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // Pixels without a start-of-frame are discarded
        repeat (4) step(1'b1, 1'b0, 8'hAA);

        // Full frame, continuous input
        obs_wins = 0; obs_eof = 0;
        send_frame(1'b0, 1'b0);
        flush();
        chk("frame_count", WBITS'(obs_wins), WBITS'(FRAME_WINS));
        chk("frame_eof_count", WBITS'(obs_eof), WBITS'(1));
        chk("first_tap22", WBITS'(first_tap22), WBITS'(PAD ? 8'h00 : 8'h22));
        chk("last_tap22", WBITS'(last_tap22), WBITS'(8'h57));

        // Same frame with i_valid toggling
        obs_wins = 0;
        send_frame(1'b1, 1'b0);
        flush();
        chk("gap_frame_count", WBITS'(obs_wins), WBITS'(FRAME_WINS));

        // Frame restarted by i_sof at pixel (3,4)
        obs_wins = 0; obs_eof = 0;
        for (int r = 0; r <= 3; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if ((r < 3) || (c < 4)) begin
                    pix_val(r, c, 1'b0, v);
                    step(1'b1, (r == 0) && (c == 0), v);
                end
            end
        end
        send_frame(1'b0, 1'b0);
        flush();
        chk("abort_count", WBITS'(obs_wins), WBITS'(ABORT_WINS + FRAME_WINS));
        chk("abort_eof_count", WBITS'(obs_eof), WBITS'(1));

        // Reset asserted mid-frame right after pixel (2,5)
        for (int r = 0; r <= 2; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if ((r < 2) || (c <= 5)) begin
                    pix_val(r, c, 1'b0, v);
                    step(1'b1, (r == 0) && (c == 0), v);
                end
            end
        end
        chk("pre_reset_valid", {{(WBITS-1){1'b0}}, o_valid}, {{(WBITS-1){1'b0}}, 1'b1});
        rst = 1'b1;
        i_valid = 1'b0;
        #1;
        check_idle_outputs("midrst");
        q.delete();
        m_active = 1'b0; m_row = 0; m_col = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (5) step(1'b1, 1'b0, 8'h33);
        obs_wins = 0; obs_eof = 0; last_tap22 = 8'hxx;
        send_frame(1'b0, 1'b0);
        flush();
        chk("post_rst_count", WBITS'(obs_wins), WBITS'(FRAME_WINS));
        chk("post_rst_last_tap22", WBITS'(last_tap22), WBITS'(8'h57));

        // Back-to-back frames, second frame inverted
        obs_wins = 0; obs_eof = 0;
        send_frame(1'b0, 1'b0);
        send_frame(1'b0, 1'b1);
        flush();
        chk("b2b_count", WBITS'(obs_wins), WBITS'(2 * FRAME_WINS));
        chk("b2b_eof_count", WBITS'(obs_eof), WBITS'(2));
        chk("b2b_last_tap22", WBITS'(last_tap22), WBITS'(8'hFF - 8'h57));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_window_nxn_gen
`default_nettype wire
